// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Next-PC controller with branch/jump/call/return, stall and halt.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int PC_W      = 8,
  parameter int RESET_VEC = 0,
  parameter int PC_INC    = 1,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            halt,
  input  logic            resume,
  output logic [PC_W-1:0] pc_out,
  output logic            pc_valid,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam int              SP_W    = $clog2(RAS_DEPTH);
  localparam logic [PC_W-1:0] C_RESET = RESET_VEC[PC_W-1:0];
  localparam logic [PC_W-1:0] C_INC   = PC_INC[PC_W-1:0];
  localparam logic [SP_W:0]   C_FULL  = RAS_DEPTH[SP_W:0];

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [SP_W-1:0] r_sp;
  logic [SP_W:0]   r_cnt;
  logic            r_ovf;
  logic            r_unf;
  logic [PC_W-1:0] r_ras [RAS_DEPTH];

  logic [1:0]      w_state_nxt;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic [SP_W-1:0] w_sp_dec;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf_set;
  logic            w_unf_set;
  logic            w_full;
  logic            w_empty;

  assign w_pc_inc = r_pc + C_INC;
  assign w_sp_dec = r_sp - SP_W'(1);
  assign w_full   = (r_cnt == C_FULL);
  assign w_empty  = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case (r_state)
      BOOT: w_state_nxt = halt ? HALT : RUN;
      RUN: begin
        if (halt) begin
          w_state_nxt = HALT;
        end else if (ret) begin
          // An empty-stack return falls through to the sequential address.
          if (w_empty) begin
            w_pc_nxt  = w_pc_inc;
            w_unf_set = 1'b1;
          end else begin
            w_pc_nxt = r_ras[w_sp_dec];
            w_pop    = 1'b1;
          end
        end else if (call) begin
          w_push    = 1'b1;
          w_ovf_set = w_full;
          w_pc_nxt  = jmp_target;
        end else if (jmp) begin
          w_pc_nxt = jmp_target;
        end else if (br_taken) begin
          w_pc_nxt = br_target;
        end else if (!stall) begin
          w_pc_nxt = w_pc_inc;
        end
      end
      HALT: begin
        if (resume && !halt) w_state_nxt = RUN;
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= C_RESET;
      r_sp    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_push) begin
        // When full the write pointer already sits on the oldest entry.
        r_sp <= r_sp + SP_W'(1);
        if (!w_full) r_cnt <= r_cnt + 1'b1;
      end else if (w_pop) begin
        r_sp  <= w_sp_dec;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      if (w_unf_set) r_unf <= 1'b1;
    end
  end

  // Stack storage needs no reset; occupancy is tracked by r_cnt.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_sp] <= w_pc_inc;
  end

  assign pc_out        = r_pc;
  assign pc_valid      = (r_state == RUN);
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Purpose  : Directed self-checking bench for pc_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       stall;
  logic       br_taken;
  logic [7:0] br_target;
  logic       jmp;
  logic       call;
  logic       ret;
  logic [7:0] jmp_target;
  logic       halt;
  logic       resume;
  logic [7:0] pc_out;
  logic       pc_valid;
  logic       ras_overflow;
  logic       ras_underflow;

  int n_cmp;
  int n_err;

  pc_sequencer #(
    .PC_W(8), .RESET_VEC(0), .PC_INC(1), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .call(call), .ret(ret), .jmp_target(jmp_target),
    .halt(halt), .resume(resume),
    .pc_out(pc_out), .pc_valid(pc_valid),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [7:0] pc, input logic v,
                             input logic ovf, input logic unf);
    check({tag, ".pc"},  32'(pc_out),        32'(pc));
    check({tag, ".vld"}, 32'(pc_valid),      32'(v));
    check({tag, ".ovf"}, 32'(ras_overflow),  32'(ovf));
    check({tag, ".unf"}, 32'(ras_underflow), 32'(unf));
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 8'h00;
    jmp = 1'b0; call = 1'b0; ret = 1'b0; jmp_target = 8'h00;
    halt = 1'b0; resume = 1'b0;

    // Reset and boot sequence
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(); check_state("boot", 8'h00, 1'b1, 1'b0, 1'b0);
    step(); check("seq1", 32'(pc_out), 32'h01);
    step(); check("seq2", 32'(pc_out), 32'h02);

    // Branch overrides stall; plain stall holds
    step(); step(); step(); check("seq5", 32'(pc_out), 32'h05);
    br_taken = 1'b1; br_target = 8'h40; stall = 1'b1;
    step(); check("br_over_stall", 32'(pc_out), 32'h40);
    br_taken = 1'b0;
    step(); check("stall_hold", 32'(pc_out), 32'h40);
    stall = 1'b0;

    // Call then return
    jmp = 1'b1; jmp_target = 8'h10;
    step(); check("jmp10", 32'(pc_out), 32'h10);
    jmp = 1'b0; call = 1'b1; jmp_target = 8'h80;
    step(); check("call80", 32'(pc_out), 32'h80);
    call = 1'b0; ret = 1'b1;
    step(); check("ret11", 32'(pc_out), 32'h11);
    ret = 1'b0;

    // Five calls overflow a 4-deep stack
    jmp = 1'b1; jmp_target = 8'h01;
    step(); check("jmp01", 32'(pc_out), 32'h01);
    jmp = 1'b0; call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jmp_target = 8'(i + 2);
      step(); check("call_chain", 32'(pc_out), 32'(i + 2));
    end
    call = 1'b0;
    check_state("after_ovf", 8'h06, 1'b1, 1'b1, 1'b0);
    ret = 1'b1;
    step(); check("ret_a", 32'(pc_out), 32'h06);
    step(); check("ret_b", 32'(pc_out), 32'h05);
    step(); check("ret_c", 32'(pc_out), 32'h04);
    step(); check("ret_d", 32'(pc_out), 32'h03);
    step(); check_state("ret_unf", 8'h04, 1'b1, 1'b1, 1'b1);
    ret = 1'b0;

    // call+ret together: ret wins and nothing is pushed
    call = 1'b1; jmp_target = 8'h20;
    step(); check("call20", 32'(pc_out), 32'h20);
    ret = 1'b1; jmp_target = 8'h90;
    step(); check("callret", 32'(pc_out), 32'h05);
    call = 1'b0;
    step(); check("no_push", 32'(pc_out), 32'h06);
    ret = 1'b0;

    // Wrap-around and halt/resume
    jmp = 1'b1; jmp_target = 8'hFF;
    step(); check("jmpFF", 32'(pc_out), 32'hFF);
    jmp = 1'b0;
    step(); check("wrap", 32'(pc_out), 32'h00);
    halt = 1'b1;
    step(); check_state("halt0", 8'h00, 1'b0, 1'b1, 1'b1);
    halt = 1'b0; jmp = 1'b1; jmp_target = 8'h55;
    step(); check_state("halt1", 8'h00, 1'b0, 1'b1, 1'b1);
    step(); check_state("halt2", 8'h00, 1'b0, 1'b1, 1'b1);
    jmp = 1'b0; resume = 1'b1;
    step(); check_state("resume", 8'h00, 1'b1, 1'b1, 1'b1);
    resume = 1'b0;
    step(); check("post_resume", 32'(pc_out), 32'h01);

    // Asynchronous reset between edges
    jmp = 1'b1; jmp_target = 8'h33;
    step(); check("jmp33", 32'(pc_out), 32'h33);
    jmp = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    // Halt while booting
    halt = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(); check_state("boot_halt", 8'h00, 1'b0, 1'b0, 1'b0);
    halt = 1'b0; resume = 1'b1;
    step(); check_state("boot_resume", 8'h00, 1'b1, 1'b0, 1'b0);
    resume = 1'b0;
    step(); check("boot_seq", 32'(pc_out), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
